// File: rtl/lcd_frame_timer.sv
// Frame-timing generator for the memory-in-pixel LCD parallel interface.
// Streams pixel words per line, alternates frame polarity and stops only after an inverted frame.
//
// state  | meaning
// IDLE   | stopped, outputs quiet, waiting for i_enable
// ACTIVE | LINES x (WORDS_PER_LINE + LINE_BLANK) word slots
// PORCH  | BACK_PORCH cycles, invert shows next-frame polarity
module lcd_frame_timer #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 1280,
  parameter int WORDS_PER_LINE = 40,
  parameter int LINE_BLANK     = 4,
  parameter int BACK_PORCH     = 24,
  parameter int UPDATE_CYCLES  = 48,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_inv_mode,
  input  logic                   i_clear_underrun,
  input  logic [DATA_WIDTH-1:0]  i_pix_data,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_valid,
  output logic                   o_update,
  output logic                   o_invert,
  output logic                   o_busy,
  output logic [15:0]            o_line,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic                   o_underrun
);

  localparam int WORDS_TOTAL = WORDS_PER_LINE + LINE_BLANK;
  localparam int WORD_W      = (WORDS_TOTAL > 1) ? $clog2(WORDS_TOTAL) : 1;
  localparam int PORCH_W     = (BACK_PORCH > 1) ? $clog2(BACK_PORCH) : 1;
  localparam int UPD_W       = $clog2(UPDATE_CYCLES + 1);

  localparam logic [WORD_W-1:0]      WORD_LAST     = WORD_W'(WORDS_TOTAL - 1);
  localparam logic [WORD_W-1:0]      WORD_DATA_END = WORD_W'(WORDS_PER_LINE);
  localparam logic [WORD_W-1:0]      WORD_ONE      = WORD_W'(1);
  localparam logic [15:0]            LINE_LAST     = 16'(LINES - 1);
  localparam logic [PORCH_W-1:0]     PORCH_LOAD    = PORCH_W'(BACK_PORCH - 1);
  localparam logic [PORCH_W-1:0]     PORCH_ONE     = PORCH_W'(1);
  localparam logic [UPD_W-1:0]       UPD_LOAD      = UPD_W'(UPDATE_CYCLES);
  localparam logic [UPD_W-1:0]       UPD_ONE       = UPD_W'(1);
  localparam logic [FRAME_CNT_W-1:0] FC_ONE        = FRAME_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PORCH  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [15:0]            line_q, line_d;
  logic [PORCH_W-1:0]     porch_q, porch_d;
  logic [UPD_W-1:0]       upd_q, upd_d;
  logic                   pol_q, pol_d;
  logic                   inv_mode_q, inv_mode_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   update_q, update_d;
  logic                   invert_q, invert_d;
  logic                   underrun_q, underrun_d;

  logic                   data_slot;
  logic                   pix_ready;
  logic                   start_frame;

  always_comb begin
    data_slot = (state_q == ST_ACTIVE) && (word_q < WORD_DATA_END);
    // legacy inverted frames leave the source untouched
    pix_ready = data_slot && (!pol_q || inv_mode_q);
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    line_d      = line_q;
    porch_d     = porch_q;
    upd_d       = upd_q;
    pol_d       = pol_q;
    inv_mode_d  = inv_mode_q;
    frame_cnt_d = frame_cnt_q;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          start_frame = 1'b1;
          pol_d       = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (upd_q != '0) begin
          upd_d = upd_q - UPD_ONE;
        end
        if (word_q == WORD_LAST) begin
          word_d = '0;
          if (line_q == LINE_LAST) begin
            line_d  = '0;
            porch_d = PORCH_LOAD;
            state_d = ST_PORCH;
          end else begin
            line_d = line_q + 16'd1;
          end
        end else begin
          word_d = word_q + WORD_ONE;
        end
      end
      ST_PORCH: begin
        if (porch_q == '0) begin
          frame_cnt_d = frame_cnt_q + FC_ONE;
          pol_d       = ~pol_q;
          // a non-inverted frame is always followed by its inverted partner
          if (i_enable || !pol_q) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          porch_d = porch_q - PORCH_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_frame) begin
      state_d    = ST_ACTIVE;
      word_d     = '0;
      line_d     = '0;
      upd_d      = UPD_LOAD;
      inv_mode_d = i_inv_mode;
    end
  end

  always_comb begin
    data_d     = '0;
    valid_d    = 1'b0;
    update_d   = 1'b0;
    invert_d   = 1'b0;
    underrun_d = underrun_q & ~i_clear_underrun;

    case (state_q)
      ST_ACTIVE: begin
        invert_d = pol_q;
        update_d = (upd_q != '0);
        if (pix_ready) begin
          valid_d = 1'b1;
          if (!i_pix_valid) begin
            underrun_d = 1'b1;
          end else if (pol_q) begin
            data_d = ~i_pix_data;
          end else begin
            data_d = i_pix_data;
          end
        end
      end
      ST_PORCH: begin
        invert_d = ~pol_q;
      end
      default: begin
        invert_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      line_q      <= '0;
      porch_q     <= '0;
      upd_q       <= '0;
      pol_q       <= 1'b0;
      inv_mode_q  <= 1'b0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      invert_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      line_q      <= line_d;
      porch_q     <= porch_d;
      upd_q       <= upd_d;
      pol_q       <= pol_d;
      inv_mode_q  <= inv_mode_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      invert_q    <= invert_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_pix_ready   = pix_ready;
  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_update      = update_q;
  assign o_invert      = invert_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_line        = (state_q == ST_ACTIVE) ? line_q : 16'd0;
  assign o_frame_count = frame_cnt_q;
  assign o_underrun    = underrun_q;

endmodule

// File: doc/lcd_frame_timer.md
Name: lcd_frame_timer

Overview:
Parametrised frame-timing generator for the memory-in-pixel LCD parallel interface. It is the successor to the fixed 1280-line / 44-clock frame loop. It produces update, invert, valid and the data word stream, and pulls pixel words from an upstream source over a ready/valid handshake. It enforces DC balance by alternating frame polarity and always stopping after an inverted frame. It adds underrun detection and a selectable inverted-frame mode. It sits between the pixel source (framebuffer or pattern generator) and the LCD pins, clocked by the PLL-derived LCD clock.

Parameters:
DATA_WIDTH, 32, width of pixel word and o_data.
LINES, 1280, lines per frame.
WORDS_PER_LINE, 40, data words per line (valid slots).
LINE_BLANK, 4, valid-low words at end of each line (≥1).
BACK_PORCH, 24, cycles after last line before next frame (≥1); invert carries next-frame polarity here.
UPDATE_CYCLES, 48, length of the update pulse from frame start (1..LINES*(WORDS_PER_LINE+LINE_BLANK)).
FRAME_CNT_W, 16, width of o_frame_count.

Ports:
i_clock  in  1  LCD pixel clock; all logic on rising edge.
i_reset  in  1  synchronous, active-high reset.
i_enable  in  1  level; 1 = run frames, 0 = stop at the next balanced frame boundary.
i_inv_mode  in  1  sampled at frame start; 0 = inverted frame drives zeros with valid low; 1 = inverted frame drives ~pixel with valid high.
i_clear_underrun  in  1  pulse; clears o_underrun.
i_pix_data  in  DATA_WIDTH  pixel word from source.
i_pix_valid  in  1  source has a word.
o_pix_ready  out  1  timer consumes i_pix_data this cycle (combinational from state/counters only, never from i_pix_valid).
o_data  out  DATA_WIDTH  registered LCD data.
o_valid  out  1  registered LCD valid.
o_update  out  1  registered update pulse.
o_invert  out  1  registered polarity.
o_busy  out  1  1 whenever not IDLE.
o_line  out  16  current line index (0 outside ACTIVE).
o_frame_count  out  FRAME_CNT_W  completed frames, wraps.
o_underrun  out  1  sticky: data slot reached with i_pix_valid=0.

Behaviour:
- Reset: state IDLE, all counters 0, polarity 0 (next frame non-inverted). o_data, o_valid, o_update, o_invert, o_busy, o_underrun and o_frame_count are all 0. Reset mid-frame aborts immediately, with no drain.
- States:
  - IDLE: transitions to ACTIVE when i_enable=1.
  - ACTIVE: runs LINES×(WORDS_PER_LINE+LINE_BLANK) cycles, then goes to PORCH.
  - PORCH: runs BACK_PORCH cycles. At its last cycle, o_frame_count increments and polarity toggles. Next state is ACTIVE if (i_enable=1 or the just-finished frame was non-inverted); otherwise IDLE.
- A stop request therefore always ends after an inverted frame. The first frame after IDLE is always non-inverted.
- Frame length: LINES×(W+B)+BACK_PORCH cycles, with no gap between frames while enabled. Going IDLE→ACTIVE costs exactly one cycle after i_enable is seen.
- Counters: the word counter runs 0..W+B-1, then wraps and increments the line counter. The line counter wraps to 0 when entering PORCH.
- o_pix_ready is 1 iff state=ACTIVE, word counter < WORDS_PER_LINE, and the frame is non-inverted or i_inv_mode latched = 1. In legacy inverted frames the source is not drained.
- Output latency is one cycle: the slot-n decision appears on o_data/o_valid at cycle n+1.
  - Non-inverted slot: o_data=i_pix_data, o_valid=1.
  - Mode-1 inverted slot: o_data=~i_pix_data, o_valid=1.
  - Legacy inverted slot: o_data=0, o_valid=0.
  - Blank words, PORCH and IDLE: o_data=0, o_valid=0.
- Underrun: if o_pix_ready=1 and i_pix_valid=0, that slot outputs o_data=0 with o_valid=1, and o_underrun sets. It is cleared only by i_clear_underrun or reset; a simultaneous set and clear resolves to set.
- o_update=1 for the first UPDATE_CYCLES cycles of ACTIVE, on the same one-cycle-registered alignment as o_data.
- o_invert tracks the current frame polarity during ACTIVE and ~polarity (next frame's polarity) during PORCH, so it is stable for BACK_PORCH cycles before update rises. It is 0 in IDLE.
- i_inv_mode is latched on the IDLE→ACTIVE and PORCH→ACTIVE transitions. Mid-frame changes are ignored.

Test Plan:
(Bench parameters LINES=3, W=4, B=2, BACK_PORCH=3, UPDATE_CYCLES=5, DATA_WIDTH=8; frame = 21 cycles.)

1. Reset, then i_enable=1 with the source always valid and data = incrementing from 0x00 → o_valid pattern per line is 1111 00. o_data is 0x00..0x0B over frame 0, with 12 ready cycles. o_update is high for exactly 5 cycles. o_invert is 0 during ACTIVE and 1 for the 3 porch cycles. o_frame_count=1 at cycle 21.
2. Continuing with i_inv_mode=0 → frame 1 has o_valid=0 and o_data=0 throughout, zero ready cycles, and o_invert=1 during ACTIVE, then 0 in PORCH. o_frame_count=2.
3. i_inv_mode=1 in the inverted frame with source data 0x0F → o_valid=1 with o_data=0xF0 in all 12 slots.
4. Drop i_enable during frame 0 (non-inverted) → frame 1 (inverted) still runs fully. Then IDLE: o_busy=0, o_frame_count=2. Re-enabling starts with o_invert=0.
5. Hold i_pix_valid=0 at line 1 word 2 → that slot gives o_data=0, o_valid=1 and o_underrun=1, which persists until an i_clear_underrun pulse. A simultaneous underrun and clear leaves o_underrun=1.
6. Assert i_reset at line 2 word 1 → next cycle all outputs are 0 and state is IDLE. With i_enable still 1, the first frame after reset is non-inverted.
